// File: rtl/mskand_pkg.sv
// Shared constants and helpers for the masked-AND scheduler.
package mskand_pkg;

  // Input/output latencies of the HPC2 gadget, in cycles after issue.
  localparam int LAT_A   = 0;
  localparam int LAT_B   = 1;
  localparam int LAT_OUT = 2;

  // Number of fresh random bits one HPC2 AND consumes for d shares.
  function automatic int hpc2rnd(input int d);
    return d * (d - 1) / 2;
  endfunction

endpackage

// File: rtl/mskand_hpc2_sched_if.sv
// Operand, randomness and result channels of the masked-AND scheduler.
//
// Handshake: a word moves on a rising clk edge where both valid and ready
// are high. A producer holds valid and its data stable until that edge.
// in_ready/rnd_ready are combinational in in_valid & rnd_valid: the operand
// pair and the randomness word are always taken together, in one cycle.
// out_data is held stable while out_valid & !out_ready.
interface mskand_hpc2_sched_if #(
  parameter int D = 2,
  parameter int R = 1
);
  logic         in_valid;
  logic         in_ready;
  logic [D-1:0] in_a;
  logic [D-1:0] in_b;
  logic         rnd_valid;
  logic         rnd_ready;
  logic [R-1:0] rnd_in;
  logic         out_valid;
  logic         out_ready;
  logic [D-1:0] out_data;

  // Scheduler side.
  modport slave (
    input  in_valid, in_a, in_b, rnd_valid, rnd_in, out_ready,
    output in_ready, rnd_ready, out_valid, out_data
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_a, in_b, rnd_valid, rnd_in, out_ready,
    input  in_ready, rnd_ready, out_valid, out_data
  );
endinterface

// File: rtl/mskand_sched_fifo.sv
// Small synchronous FIFO holding gadget results until downstream takes them.
// Head word is read straight from the storage register; empty reads as 0.
module mskand_sched_fifo #(
  parameter  int W     = 2,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mskand_hpc2_sched.sv
// Issue scheduler for one pipelined HPC2 masked AND gadget. Operands and
// randomness are issued together when a FIFO slot is reserved (credit), so
// results leaving the non-stallable gadget always have somewhere to land.
module mskand_hpc2_sched
  import mskand_pkg::*;
#(
  parameter int D       = 2,
  parameter int HPC2RND = hpc2rnd(D),
  parameter int ODEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  mskand_hpc2_sched_if.slave bus,
  output logic [D-1:0]       g_ina,
  output logic [D-1:0]       g_inb,
  output logic [HPC2RND-1:0] g_rnd,
  input  logic [D-1:0]       g_out,
  output logic               busy
);

  localparam int VDEPTH = LAT_OUT - LAT_A;
  localparam int CW     = $clog2(ODEPTH + 1);

  logic              issue;
  logic              pop;
  logic [CW-1:0]     credits;
  logic [VDEPTH-1:0] v;
  logic [D-1:0]      b_reg;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [D-1:0]      fifo_rdata;

  // Operand and randomness are consumed together; zero credits blocks both.
  assign issue         = ~rst & bus.in_valid & bus.rnd_valid & (credits != '0);
  assign bus.in_ready  = issue;
  assign bus.rnd_ready = issue;

  // Latency-0 inputs only carry data on the issuing cycle.
  assign g_ina = issue ? bus.in_a : '0;
  assign g_rnd = issue ? bus.rnd_in : '0;
  // B reaches the gadget one cycle after its A through b_reg.
  assign g_inb = b_reg;

  assign pop           = ~fifo_empty & bus.out_ready;
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_rdata;
  assign busy          = (|v) | ~fifo_empty;

  // B capture on issue; held between issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) b_reg <= '0;
    else if (issue) b_reg <= bus.in_b;
  end

  // In-flight tracking: bit k set means an op issued k+1 cycles ago.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) v <= '0;
    else v <= {v[VDEPTH-2:0], issue};
  end

  // Credits = free FIFO slots not yet reserved by in-flight ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) credits <= CW'(ODEPTH);
    else if (issue & ~pop) credits <= credits - CW'(1);
    else if (pop & ~issue) credits <= credits + CW'(1);
  end

  mskand_sched_fifo #(
    .W     (D),
    .DEPTH (ODEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (v[VDEPTH-1]),
    .wdata (g_out),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Credit bookkeeping must always account for every FIFO slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (int'(credits) <= ODEPTH);
      assert (int'(credits) + int'(fifo_count) + $countones(v) == ODEPTH);
      assert (!(v[VDEPTH-1] & fifo_full));
    end
  end

endmodule

// File: tb/tb_mskand_hpc2_sched.sv
// Bench for the masked-AND scheduler with a behavioural 2-cycle gadget.
module tb_mskand_hpc2_sched;

  localparam int D      = 2;
  localparam int R      = 1;
  localparam int ODEPTH = 4;
  localparam int LIMIT  = 60;

  typedef struct {
    logic [D-1:0] a;
    logic [D-1:0] b;
    logic [R-1:0] r;
    logic         exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [D-1:0] g_ina;
  logic [D-1:0] g_inb;
  logic [R-1:0] g_rnd;
  logic [D-1:0] g_out;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_issue  = 0;

  // Scoreboard: expected unmasked result and the cycle it becomes visible.
  logic [0:0]   exp_q[$];
  int           due_q[$];
  logic [D-1:0] last_b    = '0;
  logic         have_hold = 1'b0;
  logic [D-1:0] hold_data = '0;

  mskand_hpc2_sched_if #(.D(D), .R(R)) bus ();

  mskand_hpc2_sched #(
    .D       (D),
    .HPC2RND (R),
    .ODEPTH  (ODEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .g_ina (g_ina),
    .g_inb (g_inb),
    .g_rnd (g_rnd),
    .g_out (g_out),
    .busy  (busy)
  );

  // Clock.
  always #5 clk = ~clk;

  // Behavioural 2-share AND gadget: A and r at t, B at t+1, result at t+2.
  logic [D-1:0] ga1    = '0;
  logic [R-1:0] gr1    = '0;
  logic [D-1:0] gout_r = '0;
  always @(posedge clk) begin
    ga1       <= g_ina;
    gr1       <= g_rnd;
    gout_r[0] <= (ga1[0] & g_inb[0]) ^ gr1[0] ^ (ga1[0] & g_inb[1]);
    gout_r[1] <= (ga1[1] & g_inb[1]) ^ gr1[0] ^ (ga1[1] & g_inb[0]);
  end
  assign g_out = gout_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: an op may issue when fewer than ODEPTH ops are
  // outstanding; its result is visible 3 cycles later, in issue order.
  always @(negedge clk) begin : model
    logic exp_valid;
    logic exp_issue;
    if (rst) begin
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_rnd_ready", 32'(bus.rnd_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_g_inb", 32'(g_inb), 32'd0);
      exp_q.delete();
      due_q.delete();
      last_b    = '0;
      have_hold = 1'b0;
    end else begin
      exp_valid = (exp_q.size() > 0) && (due_q[0] <= cyc);
      exp_issue = bus.in_valid && bus.rnd_valid && (exp_q.size() < ODEPTH);
      chk("in_ready", 32'(bus.in_ready), 32'(exp_issue));
      chk("rnd_ready", 32'(bus.rnd_ready), 32'(exp_issue));
      chk("g_ina", 32'(g_ina), exp_issue ? 32'(bus.in_a) : 32'd0);
      chk("g_rnd", 32'(g_rnd), exp_issue ? 32'(bus.rnd_in) : 32'd0);
      chk("g_inb", 32'(g_inb), 32'(last_b));
      chk("busy", 32'(busy), 32'(exp_q.size() > 0));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      if (exp_valid) chk("out_xor", 32'(^bus.out_data), 32'(exp_q[0]));
      else chk("out_data_idle", 32'(bus.out_data), 32'd0);
      if (have_hold) chk("out_hold_stable", 32'(bus.out_data), 32'(hold_data));
      have_hold = exp_valid && !bus.out_ready;
      hold_data = bus.out_data;
      if (exp_valid && bus.out_ready) begin
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      if (exp_issue) begin
        exp_q.push_back((^bus.in_a) & (^bus.in_b));
        due_q.push_back(cyc + 3);
        last_b = bus.in_b;
      end
      if (bus.rnd_ready) n_issue++;
    end
    cyc++;
  end

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [D-1:0] a, input logic [D-1:0] b, input logic [R-1:0] r);
    bit accepted;
    accepted      = 1'b0;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.rnd_in    = r;
    bus.in_valid  = 1'b1;
    bus.rnd_valid = 1'b1;
    for (int k = 0; k < LIMIT && !accepted; k++) begin
      @(negedge clk);
      accepted = bus.in_ready;
      step();
    end
    bus.in_valid  = 1'b0;
    bus.rnd_valid = 1'b0;
    chk("send_accept", 32'(accepted), 32'd1);
  endtask

  task automatic single_op(input string tag, input vec_t vc);
    int lat;
    bit seen;
    seen          = 1'b0;
    bus.in_a      = vc.a;
    bus.in_b      = vc.b;
    bus.rnd_in    = vc.r;
    bus.in_valid  = 1'b1;
    bus.rnd_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_issue"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid  = 1'b0;
    bus.rnd_valid = 1'b0;
    for (lat = 1; lat <= 10; lat++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    if (seen) chk({tag, "_xor"}, 32'(^bus.out_data), 32'(vc.exp));
    step();
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < LIMIT && !idle; k++) begin
      @(negedge clk);
      idle = !busy && (exp_q.size() == 0);
    end
    chk({tag, "_drain"}, 32'(idle), 32'd1);
    step();
  endtask

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    vec_t vecs[8];
    int   n0;
    int   cnt;

    // Unmasked values: a = a0^a1, b = b0^b1, expected a&b.
    vecs[0] = '{a: 2'b10, b: 2'b01, r: 1'b1, exp: 1'b1};
    vecs[1] = '{a: 2'b11, b: 2'b01, r: 1'b1, exp: 1'b0};
    vecs[2] = '{a: 2'b01, b: 2'b11, r: 1'b0, exp: 1'b0};
    vecs[3] = '{a: 2'b00, b: 2'b10, r: 1'b1, exp: 1'b0};
    vecs[4] = '{a: 2'b01, b: 2'b10, r: 1'b0, exp: 1'b1};
    vecs[5] = '{a: 2'b11, b: 2'b00, r: 1'b1, exp: 1'b0};
    vecs[6] = '{a: 2'b10, b: 2'b10, r: 1'b0, exp: 1'b1};
    vecs[7] = '{a: 2'b01, b: 2'b01, r: 1'b1, exp: 1'b1};

    // Reset, with valids already high to show nothing issues under reset.
    bus.in_valid  = 1'b1;
    bus.rnd_valid = 1'b1;
    bus.in_a      = 2'b11;
    bus.in_b      = 2'b11;
    bus.rnd_in    = 1'b1;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) step();
    bus.in_valid  = 1'b0;
    bus.rnd_valid = 1'b0;
    rst           = 1'b0;
    step();

    // Directed single ops from the table.
    for (int i = 0; i < 8; i++) single_op($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back stream of random operands.
    n0 = n_issue;
    for (int i = 0; i < 8; i++)
      send_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    wait_idle("stream");
    chk("stream_rnd_pulses", 32'(n_issue - n0), 32'd8);

    // Randomness starvation, then release issues in the same cycle.
    bus.in_a      = 2'b01;
    bus.in_b      = 2'b10;
    bus.rnd_in    = 1'b1;
    bus.in_valid  = 1'b1;
    bus.rnd_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("starve_in_ready", 32'(bus.in_ready), 32'd0);
      chk("starve_g_ina", 32'(g_ina), 32'd0);
      chk("starve_g_rnd", 32'(g_rnd), 32'd0);
      step();
    end
    bus.rnd_valid = 1'b1;
    @(negedge clk);
    chk("starve_release", 32'(bus.rnd_ready), 32'd1);
    chk("starve_release_g_ina", 32'(g_ina), 32'd1);
    step();
    bus.in_valid  = 1'b0;
    bus.rnd_valid = 1'b0;
    wait_idle("starve");

    // Backpressure: only ODEPTH ops fit while the output is blocked.
    bus.out_ready = 1'b0;
    n0 = n_issue;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (12) step();
        @(negedge clk);
        chk("bp_issued", 32'(n_issue - n0), 32'd4);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        step();
        bus.out_ready = 1'b1;
      end
    join
    wait_idle("bp");
    chk("bp_total", 32'(n_issue - n0), 32'd6);

    // Simultaneous issue and pop with one credit left.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_op(2'b10, 2'b01, 1'b0);
    repeat (4) step();
    bus.in_a      = 2'b10;
    bus.in_b      = 2'b10;
    bus.rnd_in    = 1'b1;
    bus.in_valid  = 1'b1;
    bus.rnd_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("c1_issue", 32'(bus.in_ready), 32'd1);
    chk("c1_pop", 32'(bus.out_valid), 32'd1);
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("c1_credit_kept", 32'(bus.in_ready), 32'd1);
    step();
    @(negedge clk);
    chk("c1_no_credit", 32'(bus.in_ready), 32'd0);
    step();
    bus.in_valid  = 1'b0;
    bus.rnd_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle("c1");

    // Asynchronous reset one cycle into an operation.
    bus.in_a      = 2'b10;
    bus.in_b      = 2'b01;
    bus.rnd_in    = 1'b1;
    bus.in_valid  = 1'b1;
    bus.rnd_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_issue", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid  = 1'b0;
    bus.rnd_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    chk("mid_rst_no_result", 32'(cnt), 32'd0);
    step();
    single_op("post_rst", vecs[0]);

    // Random traffic on all three channels.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.rnd_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 4) > 1);
      bus.in_a      = 2'($urandom_range(0, 3));
      bus.in_b      = 2'($urandom_range(0, 3));
      bus.rnd_in    = 1'($urandom_range(0, 1));
      step();
    end
    bus.in_valid  = 1'b0;
    bus.rnd_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle("random");

    // Final report.
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
